// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel, run-time-programmable clock-enable generator.
//
// Each channel produces a one-cycle tick strobe plus a square wave (level)
// that toggles on every tick. Each channel runs in one of two modes:
//   - integer divide: a tick every N running clocks (N = active val)
//   - fractional NCO: phase accumulator, tick on carry-out, mean rate
//     val / 2^ACC_W ticks per clock
// New settings are first written into a per-channel shadow. They move into
// the active set only at a safe boundary, so the tick stream never glitches.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset (clears all channel state)
//   cfg_we    one-cycle config write strobe
//   cfg_ch    target channel of cfg_we (out-of-range values are ignored)
//   cfg_mode  0 = integer divide, 1 = fractional NCO
//   cfg_val   divide ratio N (integer) or phase increment (fractional)
//   run       per-channel run enable, level-sensitive
//   sync      one-cycle strobe that realigns every channel to phase zero
//   tick      registered one-cycle enable pulse per channel
//   level     registered square wave per channel, toggles on each tick
//   pend      per-channel flag: shadow config not yet applied
module clk_en_gen #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 24
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic                                          cfg_mode,
  input  logic [ACC_W-1:0]                              cfg_val,
  input  logic [NUM_CH-1:0]                             run,
  input  logic                                          sync,
  output logic [NUM_CH-1:0]                             tick,
  output logic [NUM_CH-1:0]                             level,
  output logic [NUM_CH-1:0]                             pend
);

  localparam int              CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ACC_W-1:0] ONE = ACC_W'(1);

  // Integer divider wraps when the count reaches N-1.
  function automatic logic int_wrap(input logic [ACC_W-1:0] c,
                                    input logic [ACC_W-1:0] n);
    return c == (n - ONE);
  endfunction

  // Phase accumulation with the carry kept as the extra top bit.
  function automatic logic [ACC_W:0] frac_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Per-channel registered state
  logic [NUM_CH-1:0] act_mode;
  logic [NUM_CH-1:0] shd_mode;
  logic [ACC_W-1:0]  act_val [NUM_CH];
  logic [ACC_W-1:0]  shd_val [NUM_CH];
  logic [ACC_W-1:0]  cnt     [NUM_CH];

  // Next-state values
  logic [NUM_CH-1:0] act_mode_nx;
  logic [NUM_CH-1:0] shd_mode_nx;
  logic [ACC_W-1:0]  act_val_nx [NUM_CH];
  logic [ACC_W-1:0]  shd_val_nx [NUM_CH];
  logic [ACC_W-1:0]  cnt_nx     [NUM_CH];
  logic [NUM_CH-1:0] tick_nx;
  logic [NUM_CH-1:0] level_nx;
  logic [NUM_CH-1:0] pend_nx;

  // Result of one normal counting edge under the currently active config
  logic [ACC_W-1:0]  step_cnt [NUM_CH];
  logic [ACC_W:0]    frac_sum [NUM_CH];
  logic [NUM_CH-1:0] step_tick;
  logic [NUM_CH-1:0] val_zero;
  logic [NUM_CH-1:0] do_apply;

  always_comb begin : step_logic
    step_tick = '0;
    val_zero  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      step_cnt[i] = cnt[i];
      frac_sum[i] = frac_add(cnt[i], act_val[i]);
      val_zero[i] = (act_val[i] == '0);
      // A zero ratio/increment disables the channel; stopped channels freeze.
      if (run[i] && !val_zero[i]) begin
        if (!act_mode[i]) begin
          if (int_wrap(cnt[i], act_val[i])) begin
            step_cnt[i]  = '0;
            step_tick[i] = 1'b1;
          end else begin
            step_cnt[i] = cnt[i] + ONE;
          end
        end else begin
          step_cnt[i]  = frac_sum[i][ACC_W-1:0];
          step_tick[i] = frac_sum[i][ACC_W];
        end
      end
    end
    // Safe points to swap configs: on a tick boundary (the boundary tick
    // itself still belongs to the old config), while stopped, or while the
    // channel is disabled.
    do_apply = pend & (step_tick | ~run | val_zero);
  end

  always_comb begin : next_state
    act_mode_nx = act_mode;
    shd_mode_nx = shd_mode;
    act_val_nx  = act_val;
    shd_val_nx  = shd_val;
    cnt_nx      = cnt;
    tick_nx     = '0;
    level_nx    = level;
    pend_nx     = pend;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync) begin
        // Realignment: every channel restarts from phase zero with a low
        // level. Pending configs take effect, and run is ignored.
        if (pend[i]) begin
          act_mode_nx[i] = shd_mode[i];
          act_val_nx[i]  = shd_val[i];
          pend_nx[i]     = 1'b0;
        end
        cnt_nx[i]   = '0;
        level_nx[i] = 1'b0;
      end else begin
        cnt_nx[i]   = step_cnt[i];
        tick_nx[i]  = step_tick[i];
        level_nx[i] = level[i] ^ step_tick[i];
        if (do_apply[i]) begin
          act_mode_nx[i] = shd_mode[i];
          act_val_nx[i]  = shd_val[i];
          pend_nx[i]     = 1'b0;
          // Fractional-to-fractional keeps its residue, so the long-term
          // rate stays exact across retunes. Anything else restarts.
          if (!shd_mode[i] || (shd_mode[i] != act_mode[i])) begin
            cnt_nx[i] = '0;
          end
        end
        // A write on the same edge as an apply lands in the shadow after
        // the old shadow moved to active, so it stays pending.
        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          shd_mode_nx[i] = cfg_mode;
          shd_val_nx[i]  = cfg_val;
          pend_nx[i]     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_mode <= '0;
      shd_mode <= '0;
      tick     <= '0;
      level    <= '0;
      pend     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        act_val[i] <= '0;
        shd_val[i] <= '0;
        cnt[i]     <= '0;
      end
    end else begin
      act_mode <= act_mode_nx;
      shd_mode <= shd_mode_nx;
      tick     <= tick_nx;
      level    <= level_nx;
      pend     <= pend_nx;
      for (int i = 0; i < NUM_CH; i++) begin
        act_val[i] <= act_val_nx[i];
        shd_val[i] <= shd_val_nx[i];
        cnt[i]     <= cnt_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Testbench for clk_en_gen: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a behavioural model.
module tb_clk_en_gen;

  localparam int NCH = 2;
  localparam int AW  = 24;

  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [0:0]    cfg_ch;
  logic          cfg_mode;
  logic [AW-1:0] cfg_val;
  logic [NCH-1:0] run;
  logic          sync;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] level;
  logic [NCH-1:0] pend;

  clk_en_gen #(.NUM_CH(NCH), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_val(cfg_val), .run(run), .sync(sync),
    .tick(tick), .level(level), .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cnt0  = 0;
  int cnt1  = 0;

  // Behavioural model. Integer channels track running clocks since the last
  // restart and tick on multiples of N; fractional channels track the total
  // unwrapped phase and tick whenever the whole-cycle part advances.
  bit              m_amode [NCH];
  bit              m_smode [NCH];
  bit              m_pend  [NCH];
  bit              m_tick  [NCH];
  bit              m_level [NCH];
  longint unsigned m_aval  [NCH];
  longint unsigned m_sval  [NCH];
  longint unsigned m_pos   [NCH];

  function automatic void model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit t;
      bit wr;
      t  = 1'b0;
      wr = cfg_we && (int'(cfg_ch) == c);
      if (rst) begin
        m_amode[c] = 0; m_smode[c] = 0; m_pend[c] = 0;
        m_tick[c]  = 0; m_level[c] = 0;
        m_aval[c]  = 0; m_sval[c]  = 0; m_pos[c] = 0;
      end else if (sync) begin
        if (m_pend[c]) begin
          m_amode[c] = m_smode[c];
          m_aval[c]  = m_sval[c];
          m_pend[c]  = 0;
        end
        m_pos[c] = 0; m_level[c] = 0; m_tick[c] = 0;
      end else begin
        if (run[c] && m_aval[c] != 0) begin
          if (!m_amode[c]) begin
            m_pos[c] += 1;
            t = ((m_pos[c] % m_aval[c]) == 0);
          end else begin
            t = (((m_pos[c] + m_aval[c]) >> AW) != (m_pos[c] >> AW));
            m_pos[c] += m_aval[c];
          end
        end
        m_tick[c] = t;
        if (t) m_level[c] = ~m_level[c];
        if (m_pend[c] && (t || !run[c] || m_aval[c] == 0)) begin
          if (!m_smode[c] || (m_smode[c] != m_amode[c])) m_pos[c] = 0;
          m_amode[c] = m_smode[c];
          m_aval[c]  = m_sval[c];
          m_pend[c]  = 0;
        end
        if (wr) begin
          m_smode[c] = cfg_mode;
          m_sval[c]  = 64'(cfg_val);
          m_pend[c]  = 1;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    logic [NCH-1:0] e_tick, e_level, e_pend;
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        e_tick[c]  = m_tick[c];
        e_level[c] = m_level[c];
        e_pend[c]  = m_pend[c];
      end
      chk("tick",  32'(tick),  32'(e_tick));
      chk("level", 32'(level), 32'(e_level));
      chk("pend",  32'(pend),  32'(e_pend));
      cnt0 += int'(tick[0]);
      cnt1 += int'(tick[1]);
    end
  endtask

  task automatic write_cfg(input int ch, input bit mode, input logic [AW-1:0] val);
    cfg_we   = 1'b1;
    cfg_ch   = 1'(ch);
    cfg_mode = mode;
    cfg_val  = val;
    clk_n(1);
    cfg_we   = 1'b0;
  endtask

  initial begin
    int first;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = 1'b0;
    cfg_val = '0; run = '0; sync = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_amode[c] = 0; m_smode[c] = 0; m_pend[c] = 0; m_tick[c] = 0;
      m_level[c] = 0; m_aval[c] = 0; m_sval[c] = 0; m_pos[c] = 0;
    end
    clk_n(2);
    chk("rst_tick",  32'(tick),  32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pend",  32'(pend),  32'd0);
    rst = 1'b0;

    // 1: integer divide by 12 on ch0
    write_cfg(0, 1'b0, 24'd12);
    chk("t1_pend_set", 32'(pend[0]), 32'd1);
    clk_n(1);
    chk("t1_pend_clr", 32'(pend[0]), 32'd0);
    run = 2'b01; cnt0 = 0; cnt1 = 0;
    clk_n(48);
    chk("t1_ticks0", 32'(cnt0), 32'd4);
    chk("t1_ticks1", 32'(cnt1), 32'd0);

    // 2: fractional ch1
    write_cfg(1, 1'b1, 24'h400000);
    clk_n(1);
    run = 2'b11; cnt1 = 0;
    clk_n(40);
    chk("t2_quarter", 32'(cnt1), 32'd10);
    run[1] = 1'b0;
    write_cfg(1, 1'b1, 24'h555555);
    clk_n(1);
    run[1] = 1'b1; cnt1 = 0;
    clk_n(3000);
    chk("t2_third", 32'(cnt1), 32'd999);
    run[1] = 1'b0;

    // 3: retune at the old boundary, then a write on the boundary edge
    run[0] = 1'b0;
    write_cfg(0, 1'b0, 24'd10);
    clk_n(1);
    run[0] = 1'b1;
    clk_n(3);
    write_cfg(0, 1'b0, 24'd4);
    chk("t3_pend", 32'(pend[0]), 32'd1);
    clk_n(6);
    chk("t3_old_bnd_tick", 32'(tick[0]), 32'd1);
    chk("t3_old_bnd_pend", 32'(pend[0]), 32'd0);
    clk_n(4);
    chk("t3_new_period", 32'(tick[0]), 32'd1);
    write_cfg(0, 1'b0, 24'd7);
    clk_n(2);
    write_cfg(0, 1'b0, 24'd5);
    chk("t3_same_edge_tick", 32'(tick[0]), 32'd1);
    chk("t3_same_edge_pend", 32'(pend[0]), 32'd1);
    clk_n(7);
    chk("t3_n7_tick", 32'(tick[0]), 32'd1);
    chk("t3_n7_pend", 32'(pend[0]), 32'd0);
    clk_n(5);
    chk("t3_n5_tick", 32'(tick[0]), 32'd1);

    // 4: stall stretches the period
    run[0] = 1'b0;
    write_cfg(0, 1'b0, 24'd10);
    clk_n(1);
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      run[0] = (k < 4 || k > 8);
      clk_n(1);
      if (tick[0] && first == 0) first = k;
    end
    chk("t4_stretch", 32'(first), 32'd15);

    // 5: sync realigns channels with a pending retune
    run = 2'b00;
    write_cfg(0, 1'b0, 24'd6);
    clk_n(1);
    write_cfg(1, 1'b0, 24'd6);
    clk_n(1);
    run = 2'b01;
    clk_n(2);
    run = 2'b11;
    clk_n(10);
    write_cfg(1, 1'b0, 24'd3);
    sync = 1'b1;
    clk_n(1);
    sync = 1'b0;
    chk("t5_sync_tick",  32'(tick),  32'd0);
    chk("t5_sync_level", 32'(level), 32'd0);
    chk("t5_sync_pend",  32'(pend),  32'd0);
    cnt0 = 0; cnt1 = 0;
    clk_n(12);
    chk("t5_ticks0", 32'(cnt0), 32'd2);
    chk("t5_ticks1", 32'(cnt1), 32'd4);

    // 6: reset mid-count, then a zero ratio
    rst = 1'b1;
    clk_n(1);
    rst = 1'b0;
    chk("t6_rst_tick",  32'(tick),  32'd0);
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_pend",  32'(pend),  32'd0);
    cnt0 = 0; cnt1 = 0;
    clk_n(10);
    chk("t6_idle", 32'(cnt0 + cnt1), 32'd0);
    write_cfg(0, 1'b0, 24'd0);
    clk_n(2);
    chk("t6_n0_pend", 32'(pend[0]), 32'd0);
    cnt0 = 0;
    clk_n(20);
    chk("t6_n0_ticks", 32'(cnt0), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      rst  = ($urandom_range(0, 511) == 0);
      sync = ($urandom_range(0, 63) == 0);
      run  = 2'($urandom);
      cfg_we   = !sync && ($urandom_range(0, 7) == 0);
      cfg_ch   = 1'($urandom_range(0, 1));
      cfg_mode = 1'($urandom);
      cfg_val  = cfg_mode ? 24'($urandom) : 24'($urandom_range(0, 9));
      clk_n(1);
    end
    rst = 1'b0; sync = 1'b0; cfg_we = 1'b0; run = '0;
    clk_n(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
Multi-channel, run-time-programmable clock-enable generator for the 4 MHz system domain. It replaces fixed divide-by-N toggle dividers with per-channel tick strobes, so that no derived clocks are needed. Each channel runs either as an integer divider or as a fractional phase accumulator (NCO). Typical consumers are the APU frame sequencer, serial-port shift clock, cart bus strobe and debug slow-clock.

Parameters:
NUM_CH, 2, number of independent channels (1..8)
ACC_W, 24, counter/accumulator and config value width in bits (8..32)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe (one cycle)
cfg_ch  in  max(1,$clog2(NUM_CH))  target channel of cfg_we
cfg_mode  in  1  0 = integer divide, 1 = fractional NCO
cfg_val  in  ACC_W  integer: divide ratio N; fractional: phase increment
run  in  NUM_CH  per-channel run enable, level-sensitive
sync  in  1  one-cycle strobe; realigns all channels
tick  out  NUM_CH  registered one-cycle enable pulse per channel
level  out  NUM_CH  registered square wave; toggles on every tick
pend  out  NUM_CH  staged config not yet applied

Behaviour:
- Per-channel state:
  - active {mode, val}
  - shadow {mode, val}
  - cnt/acc (ACC_W bits)
  - tick, level, pend
- Reset (any cycle, including mid-operation): all of the above go to 0 on the next edge. Active val = 0 means the channel is disabled and produces no ticks.
- Integer mode, running edge (run[i] = 1):
  - If val = 0: hold.
  - Else if cnt == val-1: cnt <= 0, tick <= 1, level <= ~level.
  - Else: cnt <= cnt+1, tick <= 0.
  - Result: exact period of N clocks. N = 1 gives tick held high and level toggling every cycle.
- Fractional mode, running edge:
  - {carry, acc} <= acc + val.
  - tick <= carry; level toggles when carry = 1.
  - Mean tick rate = val / 2^ACC_W per clk.
  - val = 0 gives no ticks.
- Stopped (run[i] = 0): cnt/acc, level and active config are frozen and tick <= 0. Resuming continues from the frozen count, so the period is stretched by exactly the stopped cycles.
- Config staging:
  - cfg_we writes the shadow of cfg_ch and sets pend the next cycle.
  - A later write before apply overwrites the shadow.
  - Out-of-range cfg_ch is ignored.
- Apply (active <= shadow, pend <= 0) happens on the first edge where pend = 1 and any of these holds:
  - (a) that edge produces a tick for the channel;
  - (b) run[i] = 0;
  - (c) active val = 0;
  - (d) sync = 1.
- On apply, cnt/acc is cleared to 0 in integer mode, and also whenever the mode changes. Otherwise (fractional to fractional) acc keeps its residue.
- An apply is always glitch-free: the tick from the boundary edge uses the old config, and the next cycle counts with the new one.
- Simultaneous cfg_we and apply on the same channel: the apply uses the shadow value registered before this edge. The new write lands in the shadow and pend stays 1.
- sync edge, all channels:
  - cnt/acc <= 0, level <= 0, tick <= 0.
  - Pending configs are applied.
  - run is ignored that cycle.
  - Afterwards, channels with equal integer N tick in the same cycle.
- rst has priority over sync, which has priority over cfg_we and normal counting.
- Latency:
  - cfg_we to pend visible: 1 cycle.
  - For a stopped channel with a pending config, the config applies on the edge after pend rises.
  - Integer channel with cnt = 0 and run rising: first tick visible after N running edges.

Test Plan:
1. rst; write ch0 int N = 12 while stopped; run[0] = 1 → tick[0] every 12 clks, level[0] period 24 clks (legacy ÷24 rate), tick[1] stays 0.
2. ch1 frac, ACC_W = 24:
   - val = 0x400000 → tick every 4 clks exactly.
   - val = 0x555555 from acc = 0 → exactly 999 ticks in 3000 running cycles.
3. ch0 int N = 10 running; write N = 4 when cnt = 3 → pend = 1 and the next tick arrives at the old 10-clk boundary. pend clears on that edge, then the period is 4. Repeat with a second write landing on the boundary edge itself → the old shadow applies and the new value stays pending.
4. run[0] dropped for 5 cycles mid-period → that period is 15 clks instead of 10, level held, no tick while stopped.
5. ch0 N = 6 and ch1 N = 6 out of phase; pulse sync with ch1 pending N = 3 → tick = 0 and level = 0 that cycle, pend[1] = 0. ch1 then ticks with ch0 every 6 clks and additionally on every 3rd clk.
6. rst asserted mid-count with ticks active → tick, level and pend are 0 the next cycle and stay 0 until a channel is reconfigured; write N = 0 → channel never ticks.
